// File: rtl/mnist_class_vote_accumulator_if.sv
// Stream and statistics bundle between the LUT-network classifier output and the
// vote accumulator. The master side drives samples; the slave side is the accumulator.
interface mnist_class_vote_accumulator_if #(
    parameter int unsigned USER_WIDTH  = 8,
    parameter int unsigned CLASS_NUM   = 10,
    parameter int unsigned CLASS_WIDTH = 4,
    parameter int unsigned STAT_WIDTH  = 32
);
    logic [USER_WIDTH-1:0]  in_user;
    logic [CLASS_NUM-1:0]   in_data;
    logic                   in_valid;

    logic [USER_WIDTH-1:0]  out_user;
    logic [CLASS_WIDTH-1:0] out_class;
    logic [CLASS_NUM-1:0]   out_onehot;
    logic                   out_match;
    logic                   out_valid;

    logic                   stat_clear;
    logic [STAT_WIDTH-1:0]  stat_total;
    logic [STAT_WIDTH-1:0]  stat_correct;

    modport master (
        output in_user, in_data, in_valid, stat_clear,
        input  out_user, out_class, out_onehot, out_match, out_valid,
        input  stat_total, stat_correct
    );

    modport slave (
        input  in_user, in_data, in_valid, stat_clear,
        output out_user, out_class, out_onehot, out_match, out_valid,
        output stat_total, stat_correct
    );
endinterface

// File: rtl/mnist_class_vote_accumulator.sv
// Accumulates per-class votes over FRAME_NUM valid samples, registers the argmax
// decision with a label-match flag, and keeps saturating accuracy counters.
module mnist_class_vote_accumulator #(
    parameter int unsigned USER_WIDTH  = 8,
    parameter int unsigned CLASS_NUM   = 10,
    parameter int unsigned FRAME_NUM   = 4,
    parameter int unsigned CLASS_WIDTH = 4,
    parameter int unsigned STAT_WIDTH  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    mnist_class_vote_accumulator_if.slave bus
);
    localparam int unsigned COUNT_WIDTH     = $clog2(FRAME_NUM + 1);
    localparam int unsigned FRAME_CNT_WIDTH = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
    localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_LAST = FRAME_CNT_WIDTH'(FRAME_NUM - 1);

    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Stage 1: accumulation
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    count_t                     vote_q [CLASS_NUM];
    logic [USER_WIDTH-1:0]      label_q;
    count_t                     res_q [CLASS_NUM];
    logic [USER_WIDTH-1:0]      res_label_q;
    logic                       res_valid_q;

    logic                       frame_first;
    logic                       frame_last;
    count_t                     sum [CLASS_NUM];
    logic [USER_WIDTH-1:0]      label_cur;

    always_comb begin
        frame_first = (frame_cnt_q == '0);
        frame_last  = (frame_cnt_q == FRAME_LAST);
        label_cur   = frame_first ? bus.in_user : label_q;
        // First sample of a frame loads rather than adds, so no separate clear is needed.
        for (int i = 0; i < CLASS_NUM; i++) begin
            sum[i] = (frame_first ? count_t'(0) : vote_q[i]) + count_t'(bus.in_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            vote_q      <= '{default: '0};
            label_q     <= '0;
            res_q       <= '{default: '0};
            res_label_q <= '0;
            res_valid_q <= 1'b0;
        end else if (cke) begin
            res_valid_q <= 1'b0;
            if (bus.in_valid) begin
                vote_q  <= sum;
                label_q <= label_cur;
                if (frame_last) begin
                    res_q       <= sum;
                    res_label_q <= label_cur;
                    res_valid_q <= 1'b1;
                    frame_cnt_q <= '0;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stage 2: decision
    logic [CLASS_WIDTH-1:0] best_idx;
    count_t                 best_val;
    logic [CLASS_NUM-1:0]   onehot_d;
    logic                   match_d;

    always_comb begin
        best_idx = '0;
        best_val = res_q[0];
        // Strict compare keeps the lowest index on ties.
        for (int i = 1; i < CLASS_NUM; i++) begin
            if (res_q[i] > best_val) begin
                best_val = res_q[i];
                best_idx = CLASS_WIDTH'(i);
            end
        end
        onehot_d = CLASS_NUM'(1) << best_idx;
        match_d  = (32'(res_label_q) < CLASS_NUM) && (32'(res_label_q) == 32'(best_idx));
    end

    logic [USER_WIDTH-1:0]  out_user_q;
    logic [CLASS_WIDTH-1:0] out_class_q;
    logic [CLASS_NUM-1:0]   out_onehot_q;
    logic                   out_match_q;
    logic                   out_valid_q;
    logic [STAT_WIDTH-1:0]  stat_total_q, stat_total_d;
    logic [STAT_WIDTH-1:0]  stat_correct_q, stat_correct_d;

    always_comb begin
        stat_total_d   = stat_total_q;
        stat_correct_d = stat_correct_q;
        if (bus.stat_clear) begin
            stat_total_d   = '0;
            stat_correct_d = '0;
        end else if (res_valid_q) begin
            if (stat_total_q != '1) begin
                stat_total_d = stat_total_q + STAT_WIDTH'(1);
            end
            if (match_d && (stat_correct_q != '1)) begin
                stat_correct_d = stat_correct_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_user_q     <= '0;
            out_class_q    <= '0;
            out_onehot_q   <= '0;
            out_match_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            stat_total_q   <= '0;
            stat_correct_q <= '0;
        end else if (cke) begin
            out_valid_q    <= res_valid_q;
            stat_total_q   <= stat_total_d;
            stat_correct_q <= stat_correct_d;
            if (res_valid_q) begin
                out_user_q   <= res_label_q;
                out_class_q  <= best_idx;
                out_onehot_q <= onehot_d;
                out_match_q  <= match_d;
            end
        end
    end

    assign bus.out_user     = out_user_q;
    assign bus.out_class    = out_class_q;
    assign bus.out_onehot   = out_onehot_q;
    assign bus.out_match    = out_match_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.stat_total   = stat_total_q;
    assign bus.stat_correct = stat_correct_q;
endmodule
